// File: rtl/control_pkg.sv
// Shared definitions for the PMIPSL0 main controller: opcode values,
// PC source encodings and the per-stage control group structs.
package control_pkg;

    // Opcodes held in the IF/ID register
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_RTYPE = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_LW    = 4'd7;
    localparam logic [3:0] OP_SW    = 4'd8;
    localparam logic [3:0] OP_BEQ   = 4'd9;
    localparam logic [3:0] OP_J     = 4'd10;

    // PC source select encodings
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Signals consumed in the EX stage
    typedef struct packed {
        logic regdst;
        logic alusrc;
        logic aluop;
    } ex_ctrl_t;

    // Signals consumed in the MEM stage
    typedef struct packed {
        logic branch;
        logic memwrite;
        logic memread;
    } mem_ctrl_t;

    // Signals consumed in the WB stage
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps the ID-stage opcode to the EX, MEM and
// WB control groups plus the ID-stage jump flag. Unlisted opcodes are NOPs.
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    output ex_ctrl_t   ex,
    output mem_ctrl_t  mem,
    output wb_ctrl_t   wb,
    output logic       jump
);

    // Opcode to control bundle; every field defaults to zero (NOP)
    always_comb begin
        ex   = '0;
        mem  = '0;
        wb   = '0;
        jump = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ex.regdst   = 1'b1;
                ex.aluop    = 1'b1;
                wb.regwrite = 1'b1;
            end
            OP_ADDI: begin
                ex.alusrc   = 1'b1;
                wb.regwrite = 1'b1;
            end
            OP_LW: begin
                ex.alusrc   = 1'b1;
                mem.memread = 1'b1;
                wb.regwrite = 1'b1;
                wb.memtoreg = 1'b1;
            end
            OP_SW: begin
                ex.alusrc    = 1'b1;
                mem.memwrite = 1'b1;
            end
            OP_BEQ: begin
                // Zero-flag qualification happens in the datapath
                mem.branch = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: begin
                ex   = '0;
                mem  = '0;
                wb   = '0;
                jump = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control.sv
// PMIPSL0 main controller. Decodes the ID-stage opcode and carries the
// control bundle through ID/EX, EX/MEM and MEM/WB registers so each signal
// appears in the cycle its stage executes. Also drives the PC source select.
// Optional feature macro: CONTROL_FLUSH_EN adds a 'flush' input that inserts
// a bubble into ID/EX and suppresses the ID-stage jump.
module control
    import control_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
`ifdef CONTROL_FLUSH_EN
    input  logic       flush,
`endif
    input  logic [3:0] Opcode,
    output logic [1:0] PCControl,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       ALUOp,
    output logic       Branch,
    output logic       Jump,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       MemtoReg
);

    ex_ctrl_t  dec_ex;
    mem_ctrl_t dec_mem;
    wb_ctrl_t  dec_wb;
    logic      dec_jump;
    logic      bubble;

    // ID/EX holds all three groups, EX/MEM the later two, MEM/WB only WB
    ex_ctrl_t  ex_p0;
    mem_ctrl_t mem_p0;
    wb_ctrl_t  wb_p0;
    mem_ctrl_t mem_p1;
    wb_ctrl_t  wb_p1;
    wb_ctrl_t  wb_p2;

    control_decode u_decode (
        .opcode (Opcode),
        .ex     (dec_ex),
        .mem    (dec_mem),
        .wb     (dec_wb),
        .jump   (dec_jump)
    );

`ifdef CONTROL_FLUSH_EN
    assign bubble = flush;
`else
    assign bubble = 1'b0;
`endif

    // ID -> EX: load the decoded bundle, or a zero bundle when bubbling
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_p0  <= '0;
            mem_p0 <= '0;
            wb_p0  <= '0;
        end else if (bubble) begin
            ex_p0  <= '0;
            mem_p0 <= '0;
            wb_p0  <= '0;
        end else begin
            ex_p0  <= dec_ex;
            mem_p0 <= dec_mem;
            wb_p0  <= dec_wb;
        end
    end

    // EX -> MEM: advance the MEM and WB groups
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_p1 <= '0;
            wb_p1  <= '0;
        end else begin
            mem_p1 <= mem_p0;
            wb_p1  <= wb_p0;
        end
    end

    // MEM -> WB: advance the WB group
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_p2 <= '0;
        end else begin
            wb_p2 <= wb_p1;
        end
    end

    // Jump is combinational from decode, masked by reset and bubble so that
    // no jump is taken while the controller is held or flushing
    assign Jump = dec_jump & reset & ~bubble;

    assign RegDst   = ex_p0.regdst;
    assign ALUSrc   = ex_p0.alusrc;
    assign ALUOp    = ex_p0.aluop;
    assign Branch   = mem_p1.branch;
    assign MemWrite = mem_p1.memwrite;
    assign MemRead  = mem_p1.memread;
    assign RegWrite = wb_p2.regwrite;
    assign MemtoReg = wb_p2.memtoreg;

    // PC source select: jump in ID overrides branch in MEM
    always_comb begin
        PCControl = PC_SEQ;
        if (Jump) begin
            PCControl = PC_JUMP;
        end else if (mem_p1.branch) begin
            PCControl = PC_BRANCH;
        end
    end

endmodule

// File: tb/tb_control.sv
// Bench for the PMIPSL0 main controller: a per-cycle vector table with
// hand-computed outputs, plus a directed asynchronous-reset sequence.
module tb_control;

    logic       clock;
    logic       reset;
    logic [3:0] Opcode;
    logic [1:0] PCControl;
    logic       RegWrite, RegDst, ALUSrc, ALUOp, Branch, Jump;
    logic       MemWrite, MemRead, MemtoReg;

    int checks = 0;
    int errors = 0;

    control dut (
        .clock     (clock),
        .reset     (reset),
        .Opcode    (Opcode),
        .PCControl (PCControl),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .Branch    (Branch),
        .Jump      (Jump),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .MemtoReg  (MemtoReg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // sig = {RegDst,ALUSrc,ALUOp, Branch,MemWrite,MemRead, RegWrite,MemtoReg, Jump}
    typedef struct packed {
        logic       rst;
        logic [3:0] op;
        logic [1:0] pc;
        logic [8:0] sig;
    } vec_t;

    localparam int NV = 26;
    vec_t vec [NV];

    function automatic logic [8:0] sig_now();
        return {RegDst, ALUSrc, ALUOp, Branch, MemWrite, MemRead,
                RegWrite, MemtoReg, Jump};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        // Row i: inputs applied after a falling edge, outputs sampled in the
        // same low phase. EX shows row i-1's opcode, MEM i-2, WB i-3.
        vec[0]  = '{1'b0, 4'd6,  2'b00, 9'b000_000_00_0}; // in reset
        vec[1]  = '{1'b1, 4'd6,  2'b00, 9'b000_000_00_0}; // released, nothing loaded yet
        vec[2]  = '{1'b1, 4'd6,  2'b00, 9'b010_000_00_0}; // addi in EX
        vec[3]  = '{1'b1, 4'd6,  2'b00, 9'b010_000_00_0}; // addi in MEM: all zero
        vec[4]  = '{1'b1, 4'd6,  2'b00, 9'b010_000_10_0}; // addi WB: RegWrite
        vec[5]  = '{1'b1, 4'd7,  2'b00, 9'b010_000_10_0}; // lw enters ID
        vec[6]  = '{1'b1, 4'd8,  2'b00, 9'b010_000_10_0}; // lw EX
        vec[7]  = '{1'b1, 4'd1,  2'b00, 9'b010_001_10_0}; // lw MEM read, sw EX
        vec[8]  = '{1'b1, 4'd0,  2'b00, 9'b101_010_11_0}; // R EX, sw MEM write, lw WB
        vec[9]  = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0}; // sw WB: no write
        vec[10] = '{1'b1, 4'd0,  2'b00, 9'b000_000_10_0}; // R WB
        vec[11] = '{1'b1, 4'd10, 2'b10, 9'b000_000_00_1}; // jump immediate
        vec[12] = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0};
        vec[13] = '{1'b1, 4'd9,  2'b00, 9'b000_000_00_0}; // beq enters ID
        vec[14] = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0};
        vec[15] = '{1'b1, 4'd10, 2'b10, 9'b000_100_00_1}; // branch in MEM + jump: jump wins
        vec[16] = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0};
        vec[17] = '{1'b1, 4'd9,  2'b00, 9'b000_000_00_0};
        vec[18] = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0};
        vec[19] = '{1'b1, 4'd0,  2'b01, 9'b000_100_00_0}; // branch select, one cycle
        vec[20] = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0};
        vec[21] = '{1'b1, 4'd3,  2'b00, 9'b000_000_00_0}; // unused opcodes
        vec[22] = '{1'b1, 4'd15, 2'b00, 9'b000_000_00_0};
        vec[23] = '{1'b1, 4'd3,  2'b00, 9'b000_000_00_0};
        vec[24] = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0};
        vec[25] = '{1'b1, 4'd0,  2'b00, 9'b000_000_00_0};

        reset  = 1'b0;
        Opcode = 4'd0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            reset  = vec[i].rst;
            Opcode = vec[i].op;
            #2;
            check($sformatf("row%0d_sig", i), {7'b0, sig_now()}, {7'b0, vec[i].sig});
            check($sformatf("row%0d_pc", i), {14'b0, PCControl}, {14'b0, vec[i].pc});
        end

        // Asynchronous reset while lw is in flight
        @(negedge clock);
        Opcode = 4'd7;
        @(negedge clock);
        Opcode = 4'd0;
        #2;
        check("lw_ex_alusrc", {15'b0, ALUSrc}, 16'd1);
        @(negedge clock);
        #2;
        check("lw_mem_read", {15'b0, MemRead}, 16'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_sig", {7'b0, sig_now()}, 16'd0);
        check("async_rst_pc", {14'b0, PCControl}, 16'd0);
        Opcode = 4'd10;
        #1;
        check("rst_jump_masked", {7'b0, sig_now()}, 16'd0);
        check("rst_jump_pc", {14'b0, PCControl}, 16'd0);
        @(negedge clock);
        reset  = 1'b1;
        Opcode = 4'd0;
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("post_rst%0d_sig", k), {7'b0, sig_now()}, 16'd0);
            check($sformatf("post_rst%0d_pc", k), {14'b0, PCControl}, 16'd0);
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
